// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: prefetching IF stage with in-order instruction FIFO; define IF_ADEF_CHECK_EN to raise ADEF on misaligned PCs
module if_prefetch_stage #(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1C000000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ertn_flush,
  input  logic [31:0] ex_ra,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_pc,
  output logic [31:0] if_to_id_inst,
  output logic        if_to_id_ex,
  output logic [14:0] if_to_id_ex_code
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  logic [31:0]           pc;
  logic [31:0]           tq [MAX_OUTSTANDING];
  logic [CW-1:0]         tags, discard;
  logic [31:0]           fpc [FIFO_DEPTH];
  logic [31:0]           finst [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fex;
  logic [FW-1:0]         rp, wp;
  logic [FW:0]           fcount;
  logic                  fetch_stall;
  logic                  redirect, acc, keep, push, pop, misaligned, adef, nonempty;
  logic [31:0]           target;
  assign redirect = wb_ex | ertn_flush | br_taken;
  assign target   = wb_ex ? ex_entry : ertn_flush ? ex_ra : br_target;
`ifdef IF_ADEF_CHECK_EN
  assign misaligned = |pc[1:0];
  assign adef = misaligned && !fetch_stall && !redirect && tags == '0 && discard == '0 &&
                int'(fcount) < FIFO_DEPTH;
`else
  assign misaligned = 1'b0;
  assign adef       = 1'b0;
`endif
  assign inst_sram_req = resetn && !redirect && !fetch_stall && !misaligned &&
                         int'(tags) + int'(discard) < MAX_OUTSTANDING &&
                         int'(fcount) + int'(tags) < FIFO_DEPTH;
  assign inst_sram_addr   = resetn ? pc : '0;
  assign acc              = inst_sram_req && inst_sram_addr_ok;
  assign keep             = inst_sram_data_ok && discard == '0 && !redirect;
  assign push             = keep || adef;
  assign nonempty         = fcount != '0;
  assign if_to_id_valid   = nonempty && !redirect;
  assign pop              = if_to_id_valid && id_allowin;
  assign if_to_id_pc      = nonempty ? fpc[rp] : '0;
  assign if_to_id_inst    = nonempty ? finst[rp] : '0;
  assign if_to_id_ex      = nonempty && fex[rp];
  assign if_to_id_ex_code = if_to_id_ex ? 15'h0008 : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      tags        <= '0;
      discard     <= '0;
      fcount      <= '0;
      rp          <= '0;
      wp          <= '0;
      fetch_stall <= 1'b0;
    end else if (redirect) begin
      pc          <= target;
      tags        <= '0;
      discard     <= CW'(int'(tags) + int'(discard) - int'(inst_sram_data_ok));
      fcount      <= '0;
      rp          <= '0;
      wp          <= '0;
      fetch_stall <= 1'b0;
    end else begin
      if (acc) pc <= pc + 32'd4;
      tags <= tags + CW'(acc) - CW'(keep);
      if (inst_sram_data_ok && discard != '0) discard <= discard - CW'(1);
      fcount <= fcount + (FW+1)'(push) - (FW+1)'(pop);
      if (pop) rp <= rp + FW'(1);
      if (push) wp <= wp + FW'(1);
      if (adef) fetch_stall <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fpc[wp]   <= keep ? tq[0] : pc;
      finst[wp] <= keep ? inst_sram_rdata : '0;
      fex[wp]   <= adef;
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (keep) tq[i] <= tq[(i + 1) % MAX_OUTSTANDING];
      if (acc && i == int'(tags) - int'(keep)) tq[i] <= pc;
    end
  end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage: scoreboard bench with a latency-programmable bus model
module tb_if_prefetch_stage;
  localparam logic [31:0] RPC = 32'h1C000000;
  logic        clk = 0, resetn = 0;
  logic        inst_sram_req, inst_sram_addr_ok = 0, inst_sram_data_ok = 0;
  logic [31:0] inst_sram_addr, inst_sram_rdata = 0;
  logic        br_taken = 0, ertn_flush = 0, wb_ex = 0, id_allowin = 1;
  logic [31:0] br_target = 0, ex_ra = 0, ex_entry = 0;
  logic        if_to_id_valid, if_to_id_ex;
  logic [31:0] if_to_id_pc, if_to_id_inst;
  logic [14:0] if_to_id_ex_code;

  if_prefetch_stage dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .br_taken(br_taken), .br_target(br_target), .ertn_flush(ertn_flush), .ex_ra(ex_ra),
    .wb_ex(wb_ex), .ex_entry(ex_entry), .id_allowin(id_allowin),
    .if_to_id_valid(if_to_id_valid), .if_to_id_pc(if_to_id_pc), .if_to_id_inst(if_to_id_inst),
    .if_to_id_ex(if_to_id_ex), .if_to_id_ex_code(if_to_id_ex_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic ex; logic [14:0] code; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  exp_t  exp_q[$];
  pend_t pend[$];
  int checks = 0, failures = 0, cyc = 0;
  int budget = 0, lat = 1, accepts = 0, outstanding = 0, max_out = 0, last_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic ex);
    exp_q.push_back('{pc, ex ? 32'h0 : mem(pc), ex, ex ? 15'h0008 : 15'h0});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || outstanding != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Bus model: responses in order, each one lat cycles after its accept
  always @(negedge clk) begin
    #3;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      inst_sram_data_ok = 1;
      inst_sram_rdata   = mem(pend[0].addr);
      void'(pend.pop_front());
      outstanding--;
    end else begin
      inst_sram_data_ok = 0;
      inst_sram_rdata   = 0;
    end
    inst_sram_addr_ok = budget > 0;
    #1;
    if (inst_sram_req && inst_sram_addr_ok) begin
      pend.push_back('{inst_sram_addr, cyc + lat});
      budget--;
      accepts++;
      outstanding++;
      if (outstanding > max_out) max_out = outstanding;
      checks++;
      if (outstanding > 2) begin
        failures++;
        $display("FAIL outstanding actual=%0d required<=2", outstanding);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (resetn && if_to_id_valid && id_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_entry actual_pc=%h required=none", if_to_id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", if_to_id_pc, e.pc);
        chk("id_inst", if_to_id_inst, e.inst);
        chk("id_ex", 32'(if_to_id_ex), 32'(e.ex));
        chk("id_code", 32'(if_to_id_ex_code), 32'(e.code));
        last_pop = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] np, tgt[3];
    logic [2:0]  vec[3];
    int start, a0;
    vec = '{3'b111, 3'b011, 3'b001};
    tgt = '{32'h1C000200, 32'h1C000300, 32'h1C000400};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(inst_sram_req), 0);
    chk("rst_addr", inst_sram_addr, 0);
    chk("rst_valid", 32'(if_to_id_valid), 0);
    chk("rst_ex", 32'(if_to_id_ex), 0);
    @(negedge clk);
    resetn = 1;
    #1;
    chk("first_req", 32'(inst_sram_req), 1);
    chk("first_addr", inst_sram_addr, RPC);
    // zero-wait streaming
    start = cyc;
    budget = 8;
    lat = 1;
    for (int i = 0; i < 8; i++) push_exp(RPC + 32'(4 * i), 0);
    drain("stream");
    chk("stream_last_cycle", 32'(last_pop - start), 9);
    np = RPC + 32;
    // back-pressure fills exactly FIFO_DEPTH entries
    @(negedge clk);
    id_allowin = 0;
    a0 = accepts;
    budget = 10;
    for (int i = 0; i < 10; i++) push_exp(np + 32'(4 * i), 0);
    repeat (12) @(negedge clk);
    #1;
    chk("bp_accepts", 32'(accepts - a0), 4);
    chk("bp_req", 32'(inst_sram_req), 0);
    chk("bp_valid", 32'(if_to_id_valid), 1);
    id_allowin = 1;
    drain("bp_drain");
    np = np + 40;
    // slow bus, outstanding limit
    @(negedge clk);
    lat = 3;
    max_out = 0;
    budget = 6;
    for (int i = 0; i < 6; i++) push_exp(np + 32'(4 * i), 0);
    drain("slow");
    chk("max_outstanding", 32'(max_out), 2);
    // branch with two requests in flight and a non-empty FIFO
    @(negedge clk);
    id_allowin = 0;
    budget = 4;
    repeat (6) @(negedge clk);
    #1;
    chk("pre_br_valid", 32'(if_to_id_valid), 1);
    chk("pre_br_outstanding", 32'(outstanding), 2);
    br_taken = 1;
    br_target = 32'h1C000100;
    id_allowin = 1;
    budget = 3;
    for (int i = 0; i < 3; i++) push_exp(32'h1C000100 + 32'(4 * i), 0);
    #1;
    chk("br_valid_forced", 32'(if_to_id_valid), 0);
    chk("br_req_forced", 32'(inst_sram_req), 0);
    @(negedge clk);
    br_taken = 0;
    drain("branch");
    // redirect priority
    lat = 1;
    ex_entry = tgt[0];
    ex_ra = tgt[1];
    br_target = tgt[2];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {wb_ex, ertn_flush, br_taken} = vec[i];
      budget = 1;
      push_exp(tgt[i], 0);
      @(negedge clk);
      {wb_ex, ertn_flush, br_taken} = 3'b000;
      #1;
      chk("redirect_addr", inst_sram_addr, tgt[i]);
      chk("redirect_req", 32'(inst_sram_req), 1);
      drain("redirect");
    end
`ifdef IF_ADEF_CHECK_EN
    @(negedge clk);
    br_taken = 1;
    br_target = 32'h1C000102;
    budget = 2;
    a0 = accepts;
    push_exp(32'h1C000102, 1);
    @(negedge clk);
    br_taken = 0;
    #1;
    chk("adef_req", 32'(inst_sram_req), 0);
    repeat (5) @(negedge clk);
    #1;
    chk("adef_no_accept", 32'(accepts - a0), 0);
    chk("adef_stall_req", 32'(inst_sram_req), 0);
    wb_ex = 1;
    ex_entry = 32'h1C000500;
    push_exp(32'h1C000500, 0);
    push_exp(32'h1C000504, 0);
    @(negedge clk);
    wb_ex = 0;
    drain("adef_recover");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with an in-order prefetch queue. It issues fetches ahead of decode on a request/address-ok/data-ok instruction bus, supporting several outstanding requests, and buffers returned instructions in a FIFO of configurable depth. It redirects on exception entry, `ertn` and taken branches by discarding in-flight and buffered instructions. It sits between the instruction SRAM-like interface and the ID stage and is the drop-in successor of the single-entry fetch stage.

## Interface
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unreturned bus requests; 1..FIFO_DEPTH.
- `RESET_PC`, 32'h1C000000: first fetch address after reset.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `inst_sram_req` out 1: fetch request valid.
- `inst_sram_addr` out 32: fetch address, equal to the current PC.
- `inst_sram_addr_ok` in 1: request accepted when high together with `inst_sram_req`.
- `inst_sram_data_ok` in 1: one response returned, in request order.
- `inst_sram_rdata` in 32: instruction word, valid with `data_ok`.
- `br_taken` in 1, `br_target` in 32: branch redirect.
- `ertn_flush` in 1, `ex_ra` in 32: exception-return redirect.
- `wb_ex` in 1, `ex_entry` in 32: exception redirect.
- `id_allowin` in 1: ID accepts the head entry this cycle.
- `if_to_id_valid` out 1: head entry valid.
- `if_to_id_pc` out 32, `if_to_id_inst` out 32: head entry PC and instruction.
- `if_to_id_ex` out 1, `if_to_id_ex_code` out 15: head entry fetch exception, `{esubcode[8:0], ecode[5:0]}`.

## Operation
- Redirect priority: `wb_ex` > `ertn_flush` > `br_taken`. `redirect` is the OR of all three. The target is selected by that priority.
- PC register: reset to `RESET_PC`. On redirect, loads the target. Otherwise increments by 4 on each accepted request (`req && addr_ok`).
- Tag queue: depth `MAX_OUTSTANDING`; holds the PC of each accepted request and pops on each kept `data_ok`.
- `discard` counter, width clog2(MAX_OUTSTANDING)+1:
  - On redirect, loads the number of outstanding tags after this cycle's accept and return. The tag queue is cleared.
  - Each `data_ok` while `discard>0` decrements it, and the data is dropped.
- Issue rule: `inst_sram_req = !redirect && fetch_stall==0 && (tags+discard) < MAX_OUTSTANDING && (fifo_count+tags) < FIFO_DEPTH`. `req` may drop without `addr_ok`.
- Kept `data_ok` pushes `{tag_pc, rdata, ex=0, code=0}` into the FIFO. Space is guaranteed by the issue rule.
- FIFO pop on `if_to_id_valid && id_allowin`.
- A redirect clears the FIFO at the next edge. `if_to_id_valid` is forced 0 in the redirect cycle and no pop occurs.
- Simultaneous events:
  - push+pop on a full FIFO is legal.
  - A `data_ok` in a redirect cycle is dropped.
  - An `addr_ok` in a redirect cycle cannot occur, because `req` is 0.

## Timing
- Reset (`resetn` low, asynchronous): PC = `RESET_PC`, FIFO empty, tags 0, `discard` 0, `fetch_stall` 0. All outputs are 0.
- First `req` is driven the first cycle after `resetn` rises, with `addr` = `RESET_PC`.
- Latency: `data_ok` in cycle N → `if_to_id_valid` in cycle N+1. There is no bypass path.
- With a zero-wait bus (`addr_ok` always 1, `data_ok` one cycle after accept), sustained throughput is one instruction per cycle.
- A redirect in cycle N → the first request to the target is in cycle N+1, provided the issue rule allows it.

## Configuration
- `IF_ADEF_CHECK_EN` defined:
  - A misaligned PC (`pc[1:0]!=0`) issues no bus request.
  - When tags==0, `discard`==0 and the FIFO is not full, the block pushes `{pc, 32'h0, ex=1, code=15'h0008}` (ADEF) and sets `fetch_stall`.
  - `fetch_stall` blocks issue until the next redirect, which clears it.
- `IF_ADEF_CHECK_EN` not defined:
  - No alignment check is made. `if_to_id_ex`/`if_to_id_ex_code` are constant 0 and `fetch_stall` is never set.

## Test plan
- Reset, zero-wait bus, `id_allowin`=1 → addresses 1C000000, 1C000004, … on consecutive cycles. Each instruction reaches ID one cycle after its `data_ok`, in order.
- `id_allowin`=0 with a zero-wait bus → exactly `FIFO_DEPTH` entries are buffered, then `req` stays 0. Raising `id_allowin` drains them in PC order with no loss.
- `data_ok` delayed 3 cycles, `MAX_OUTSTANDING`=2 → never more than 2 accepts without a return. PCs still pair correctly with returned words.
- Two requests outstanding, `br_taken` with target 1C000100 → both late `data_ok`s are discarded, the FIFO is flushed, and the next ID entry has PC 1C000100.
- `wb_ex`, `ertn_flush` and `br_taken` in the same cycle → the next fetch address is `ex_entry`.
- With `IF_ADEF_CHECK_EN`, `br_target`=1C000102 → no request to 1C000102. ID receives `ex`=1, code 0008, PC 1C000102, and fetch stalls until `wb_ex` redirects to `ex_entry`.
